// File: rtl/baud_pkg.sv
// Shared constants and types for the programmable baud tick generator.
// Defaults match a 16x oversampled UART divided from the system clock.
package baud_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int FRAC_W_DEF      = 4;
  localparam int OS_RATIO_DEF    = 16;
  localparam int DEFAULT_DIV_DEF = 325;
  localparam int OS_IDX_W_DEF    = $clog2(OS_RATIO_DEF);

  typedef logic [CNT_W_DEF-1:0]    baud_div_t;
  typedef logic [OS_IDX_W_DEF-1:0] os_idx_t;

  // Next oversample index with wrap at ratio-1.
  function automatic os_idx_t os_idx_next(
    input os_idx_t idx,
    input int      ratio
  );
    if (int'(idx) == ratio - 1) return '0;
    return idx + os_idx_t'(1);
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator for the baud generator.
// carry_o stretches the current oversample period by one cycle.
module baud_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              tick_i,
  input  logic              restart_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              carry_o
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;

  assign sum     = {1'b0, acc_q} + {1'b0, frac_i};
  assign carry_o = sum[FRAC_W];

  // Advance on each oversample tick, clear on phase restart.
  always_comb begin
    acc_d = acc_q;
    unique case (1'b1)
      restart_i: acc_d = '0;
      tick_i:    acc_d = sum[FRAC_W-1:0];
      default:   acc_d = acc_q;
    endcase
  end

  // Accumulator register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/baud_gen_prog.sv
// Programmable oversample/bit/mid-bit tick generator.
// Fractional divisor enabled by defining BAUD_GEN_FRAC_EN.
module baud_gen_prog
  import baud_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int OS_RATIO    = OS_RATIO_DEF,
  parameter int FRAC_W      = FRAC_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic                        i_restart,
  input  logic                        i_div_load,
  input  logic [CNT_W-1:0]            i_div_int,
  input  logic [FRAC_W-1:0]           i_div_frac,
  output logic                        o_os_tick,
  output logic                        o_bit_tick,
  output logic                        o_mid_tick,
  output logic [$clog2(OS_RATIO)-1:0] o_os_idx
);

  localparam int IDX_W = $clog2(OS_RATIO);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(OS_RATIO - 1);
  localparam logic [IDX_W-1:0] IDX_MID =
    IDX_W'(OS_RATIO / 2 - 1);
  localparam logic [CNT_W-1:0] DIV_RST =
    CNT_W'(DEFAULT_DIV);

  // One extra bit so div=all-ones plus carry still compares.
  logic [CNT_W:0]     cnt_q, cnt_d;
  logic [CNT_W:0]     lim;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   div_sh_q, div_sh_d;
  logic               pend_q, pend_d;
  logic               carry;
  logic               os_tick;
  logic               count_en;
  logic               apply;

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0]  frac_q, frac_d;
  logic [FRAC_W-1:0]  frac_sh_q, frac_sh_d;

  baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .tick_i    (os_tick),
    .restart_i (i_restart),
    .frac_i    (frac_q),
    .carry_o   (carry)
  );

  // Fractional divisor: shadow capture and active copy.
  always_comb begin
    frac_d    = frac_q;
    frac_sh_d = frac_sh_q;
    if (i_div_load) frac_sh_d = i_div_frac;
    if (apply) begin
      frac_d = i_div_load ? i_div_frac : frac_sh_q;
    end
  end

  // Fractional divisor registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frac_q    <= '0;
      frac_sh_q <= '0;
    end else begin
      frac_q    <= frac_d;
      frac_sh_q <= frac_sh_d;
    end
  end
`else
  logic frac_unused;
  assign frac_unused = ^i_div_frac;
  assign carry       = 1'b0;
`endif

  assign lim = {1'b0, div_q}
             + {{CNT_W{1'b0}}, carry};

  assign os_tick  = i_en && !i_restart
                 && (cnt_q == lim);
  assign count_en = i_en && !i_restart
                 && !os_tick;

  assign o_os_tick  = os_tick;
  assign o_bit_tick = os_tick && (idx_q == IDX_LAST);
  assign o_mid_tick = os_tick && (idx_q == IDX_MID);
  assign o_os_idx   = idx_q;

  // Reload is safe at a boundary, while stopped, or on restart.
  assign apply = (i_div_load || pend_q)
              && (os_tick || !i_en || i_restart);

  // Period counter and oversample phase.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    unique case (1'b1)
      i_restart: begin
        cnt_d = '0;
        idx_d = '0;
      end
      os_tick: begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_LAST)
              ? '0
              : idx_q + IDX_W'(1);
      end
      count_en: begin
        cnt_d = cnt_q + {{CNT_W{1'b0}}, 1'b1};
      end
      default: begin
        cnt_d = cnt_q;
        idx_d = idx_q;
      end
    endcase
  end

  // Integer divisor: shadow capture, pending flag, active copy.
  always_comb begin
    div_d    = div_q;
    div_sh_d = div_sh_q;
    pend_d   = pend_q;
    if (i_div_load) begin
      div_sh_d = i_div_int;
      pend_d   = 1'b1;
    end
    if (apply) begin
      div_d  = i_div_load ? i_div_int : div_sh_q;
      pend_d = 1'b0;
    end
  end

  // Phase state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Divisor registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q    <= DIV_RST;
      div_sh_q <= DIV_RST;
      pend_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      div_sh_q <= div_sh_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_baud_gen_prog.sv
// Bench for baud_gen_prog: random and directed stimulus
// against a period-level reference model.
module tb_baud_gen_prog;

  localparam int OSR = 16;
  localparam int FR  = 16;
`ifdef BAUD_GEN_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rs = 1'b0;
  logic        ld = 1'b0;
  logic [15:0] di = '0;
  logic [3:0]  df = '0;
  logic        os, bt, mt;
  logic [3:0]  idx;

  always #5 clk = ~clk;

  baud_gen_prog dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_restart  (rs),
    .i_div_load (ld),
    .i_div_int  (di),
    .i_div_frac (df),
    .o_os_tick  (os),
    .o_bit_tick (bt),
    .o_mid_tick (mt),
    .o_os_idx   (idx)
  );

  int vec = 0;
  int mis = 0;

  int m_div, m_frac, m_acc, m_el, m_idx;
  int m_sdiv, m_sfrac;
  bit m_pend;
  logic [6:0] exp_v, obs_v;

  function automatic int carry_of(input int acc, input int fr);
    return (FRAC_ON && (acc + fr >= FR)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_div = 325; m_frac = 0; m_acc = 0;
    m_el = 0; m_idx = 0;
    m_sdiv = 325; m_sfrac = 0; m_pend = 0;
  endtask

  // Drive one cycle, predict outputs, advance the model.
  task automatic cyc(input bit e, input bit r, input bit l,
                     input int d, input int f);
    int lim;
    bit tk, ap;
    @(negedge clk);
    en = e; rs = r; ld = l;
    di = 16'(d); df = 4'(f);
    #1;
    lim = m_div + carry_of(m_acc, m_frac);
    tk = e && !r && (m_el == lim);
    exp_v = {tk, tk && (m_idx == OSR-1),
             tk && (m_idx == OSR/2-1), 4'(m_idx)};
    obs_v = {os, bt, mt, idx};
    ap = (l || m_pend) && (tk || !e || r);
    if (r) begin
      m_el = 0; m_idx = 0; m_acc = 0;
    end else if (tk) begin
      m_el = 0;
      m_idx = (m_idx + 1) % OSR;
      m_acc = (m_acc + m_frac) % FR;
    end else if (e) begin
      m_el++;
    end
    if (ap) begin
      m_div = l ? d : m_sdiv;
      m_frac = l ? f : m_sfrac;
      m_pend = 0;
    end
    if (l) begin
      m_sdiv = d; m_sfrac = f;
      if (!ap) m_pend = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    #2;
    obs_v = {os, bt, mt, idx};
    vec++;
    if (obs_v !== 7'b0) begin
      mis++;
      $display("FAIL reset_outs got=%b exp=%b", obs_v, 7'b0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0);
      vec++;
      if (obs_v !== exp_v) begin
        mis++;
        $display("FAIL reset_idle got=%b exp=%b", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_default();
    int f_os, f_mid, f_bit, s_bit;
    f_os = 0; f_mid = 0; f_bit = 0; s_bit = 0;
    for (int t = 1; t <= 10432; t++) begin
      cyc(1, 0, 0, 0, 0);
      vec++;
      if (obs_v !== exp_v) begin
        mis++;
        $display("FAIL default t=%0d got=%b exp=%b", t, obs_v, exp_v);
      end
      if (obs_v[6] && f_os == 0) f_os = t;
      if (obs_v[4] && f_mid == 0) f_mid = t;
      if (obs_v[5]) begin
        if (f_bit == 0) f_bit = t;
        else if (s_bit == 0) s_bit = t;
      end
    end
    vec++;
    if (f_os != 326) begin
      mis++;
      $display("FAIL first_os got=%0d exp=326", f_os);
    end
    vec++;
    if (f_mid != 2608) begin
      mis++;
      $display("FAIL first_mid got=%0d exp=2608", f_mid);
    end
    vec++;
    if (f_bit != 5216 || s_bit != 10432) begin
      mis++;
      $display("FAIL bit_ticks got=%0d,%0d exp=5216,10432", f_bit, s_bit);
    end
  endtask

  task automatic test_load_mid();
    int w, n;
    repeat (100) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 3, 0);
    w = 0;
    for (int i = 1; i <= 400 && w == 0; i++) begin
      cyc(1, 0, 0, 0, 0);
      vec++;
      if (obs_v !== exp_v) begin
        mis++;
        $display("FAIL load_mid got=%b exp=%b", obs_v, exp_v);
      end
      if (obs_v[6]) w = i;
    end
    vec++;
    if (w != 225) begin
      mis++;
      $display("FAIL load_old_period got=%0d exp=225", w);
    end
    n = 0;
    for (int i = 0; i < 120; i++) begin
      cyc(1, 0, 0, 0, 0);
      vec++;
      if (obs_v !== exp_v) begin
        mis++;
        $display("FAIL load_new got=%b exp=%b", obs_v, exp_v);
      end
      if (obs_v[6]) n++;
    end
    vec++;
    if (n != 30) begin
      mis++;
      $display("FAIL load_tick_count got=%0d exp=30", n);
    end
  endtask

  task automatic test_frac();
    int n64, n68;
    n64 = 0; n68 = 0;
    cyc(1, 1, 1, 3, 4);
    for (int t = 1; t <= 68; t++) begin
      cyc(1, 0, 0, 0, 0);
      vec++;
      if (obs_v !== exp_v) begin
        mis++;
        $display("FAIL frac got=%b exp=%b", obs_v, exp_v);
      end
      if (obs_v[6]) begin
        n68++;
        if (t <= 64) n64++;
      end
    end
    vec++;
    if (n68 != (FRAC_ON ? 16 : 17) ||
        n64 != (FRAC_ON ? 15 : 16)) begin
      mis++;
      $display("FAIL frac_counts got=%0d/%0d exp=%0d/%0d",
               n64, n68, FRAC_ON ? 15 : 16, FRAC_ON ? 16 : 17);
    end
  endtask

  task automatic test_en_hold();
    int d, w, hold_idx;
    bit bad;
    d = int'($urandom_range(40, 6));
    cyc(0, 1, 1, d, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0);
    hold_idx = m_idx;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 0, 0, 0, 0);
      vec++;
      if (obs_v !== exp_v) begin
        mis++;
        $display("FAIL en_hold got=%b exp=%b", obs_v, exp_v);
      end
      if (obs_v[6:4] != 3'b0 || int'(obs_v[3:0]) != hold_idx) bad = 1;
    end
    vec++;
    if (bad) begin
      mis++;
      $display("FAIL en_hold_frozen got=changed exp=idx %0d", hold_idx);
    end
    w = 0;
    for (int i = 1; i <= 2 * d + 10 && w == 0; i++) begin
      cyc(1, 0, 0, 0, 0);
      vec++;
      if (obs_v !== exp_v) begin
        mis++;
        $display("FAIL en_resume got=%b exp=%b", obs_v, exp_v);
      end
      if (obs_v[6]) w = i;
    end
    vec++;
    if (w != d - 4) begin
      mis++;
      $display("FAIL en_resume_wait got=%0d exp=%0d", w, d - 4);
    end
  endtask

  task automatic test_restart_bit();
    bit hit;
    int w;
    hit = 0;
    cyc(1, 1, 1, 3, 0);
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_idx == OSR - 1 && m_el == m_div) begin
        hit = 1;
        cyc(1, 1, 0, 0, 0);
        vec++;
        if (obs_v[6:4] !== 3'b000) begin
          mis++;
          $display("FAIL restart_no_tick got=%b exp=000", obs_v[6:4]);
        end
      end else begin
        cyc(1, 0, 0, 0, 0);
        vec++;
        if (obs_v !== exp_v) begin
          mis++;
          $display("FAIL restart_run got=%b exp=%b", obs_v, exp_v);
        end
      end
    end
    vec++;
    if (!hit) begin
      mis++;
      $display("FAIL restart_reach got=0 exp=1");
    end
    w = 0;
    for (int i = 1; i <= 20 && w == 0; i++) begin
      cyc(1, 0, 0, 0, 0);
      vec++;
      if (i == 1 && obs_v[3:0] !== 4'd0) begin
        mis++;
        $display("FAIL restart_idx got=%0d exp=0", obs_v[3:0]);
      end
      if (obs_v[6]) w = i;
    end
    vec++;
    if (w != 4) begin
      mis++;
      $display("FAIL restart_next got=%0d exp=4", w);
    end
  endtask

  task automatic test_div0();
    int n;
    n = 0;
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0, 0);
      vec++;
      if (obs_v !== exp_v) begin
        mis++;
        $display("FAIL div0 got=%b exp=%b", obs_v, exp_v);
      end
      if (obs_v[6]) n++;
    end
    vec++;
    if (n != 20) begin
      mis++;
      $display("FAIL div0_count got=%0d exp=20", n);
    end
  endtask

  task automatic test_random();
    bit e, r, l;
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom % 10) != 0;
      r = ($urandom % 60) == 0;
      l = ($urandom % 40) == 0;
      cyc(e, r, l, int'($urandom_range(9, 0)),
          int'($urandom % 16));
      vec++;
      if (obs_v !== exp_v) begin
        mis++;
        $display("FAIL random i=%0d got=%b exp=%b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    cyc(1, 1, 1, 3, 0);
    repeat (2) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 5, 0);
    cyc(1, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    obs_v = {os, bt, mt, idx};
    vec++;
    if (obs_v !== 7'b0) begin
      mis++;
      $display("FAIL reset_mid got=%b exp=%b", obs_v, 7'b0);
    end
    @(negedge clk);
    en = 1'b0; ld = 1'b0; rs = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    w = 0;
    for (int i = 1; i <= 400 && w == 0; i++) begin
      cyc(1, 0, 0, 0, 0);
      vec++;
      if (obs_v !== exp_v) begin
        mis++;
        $display("FAIL reset_mid_run got=%b exp=%b", obs_v, exp_v);
      end
      if (obs_v[6]) w = i;
    end
    vec++;
    if (w != 326) begin
      mis++;
      $display("FAIL reset_mid_div got=%0d exp=326", w);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_load_mid();
    test_frac();
    test_en_hold();
    test_restart_bit();
    test_div0();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
